// File: rtl/run_length_encoder_if.sv
// Record output stream of the run-length encoder.
// The master (encoder) presents the head record with Out_valid/Out_bit/Out_len.
// The slave (consumer) answers with Out_ready. A record is consumed on a
// rising clock edge where Out_valid and Out_ready are both high.
//   Out_valid : head record present
//   Out_ready : consumer accepts the head record this cycle
//   Out_bit   : bit value of the head record
//   Out_len   : run length of the head record (CNT_W bits)
interface run_length_encoder_if #(
  parameter int CNT_W = 8
);
  logic             Out_valid;
  logic             Out_ready;
  logic             Out_bit;
  logic [CNT_W-1:0] Out_len;

  modport master (
    output Out_valid,
    output Out_bit,
    output Out_len,
    input  Out_ready
  );

  modport slave (
    input  Out_valid,
    input  Out_bit,
    input  Out_len,
    output Out_ready
  );
endinterface

// File: rtl/run_length_encoder.sv
// Run-length encoder: turns a 1-bit sample stream (one sample per clock) and
// the upstream bit-change pulse into (bit, length) records, buffers them in a
// small FIFO and drains them through a valid/ready stream.
// Ports:
//   Clk        : clock, all state on the rising edge
//   Clr        : asynchronous active-high reset
//   X          : serial sample
//   Edge       : high when X differs from the previous cycle's X
//   Flush      : single-cycle request to emit the partial current run
//   out_if     : record stream (Out_valid/Out_ready/Out_bit/Out_len)
//   Overflow   : sticky, a record was dropped because the FIFO was full
//   Fifo_count : number of stored records
module run_length_encoder #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     Clk,
  input  logic                     Clr,
  input  logic                     X,
  input  logic                     Edge,
  input  logic                     Flush,
  run_length_encoder_if.master     out_if,
  output logic                     Overflow,
  output logic [$clog2(DEPTH):0]   Fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LMAX = '1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             run_bit_q, run_bit_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;

  logic             push;
  logic             push_bit;
  logic [CNT_W-1:0] push_len;

  logic             mem_bit_q [DEPTH];
  logic [CNT_W-1:0] mem_len_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             not_empty;
  logic             pop;
  logic             accept;

  // Run tracker: next state and record generation
  always_comb begin
    state_d   = state_q;
    run_bit_d = run_bit_q;
    run_len_d = run_len_q;
    push      = 1'b0;
    push_bit  = run_bit_q;
    push_len  = run_len_q;
    unique case (state_q)
      IDLE: begin
        state_d   = RUN;
        run_bit_d = X;
        run_len_d = CNT_W'(1);
      end
      RUN: begin
        if (Flush) begin
          // The sample arriving with the flush is not part of any run.
          push      = 1'b1;
          state_d   = IDLE;
          run_len_d = '0;
        end else if (Edge) begin
          push      = 1'b1;
          run_bit_d = X;
          run_len_d = CNT_W'(1);
        end else if (run_len_q == LMAX) begin
          // Split an over-long run; the current sample opens the next chunk.
          push      = 1'b1;
          run_len_d = CNT_W'(1);
        end else begin
          run_len_d = run_len_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q   <= IDLE;
      run_bit_q <= 1'b0;
      run_len_q <= '0;
    end else begin
      state_q   <= state_d;
      run_bit_q <= run_bit_d;
      run_len_q <= run_len_d;
    end
  end

  // FIFO control: a pop in the same cycle frees the slot a full push needs
  assign not_empty = (count_q != '0);
  assign pop       = not_empty && out_if.Out_ready;
  assign accept    = push && ((count_q != FULL_CNT) || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (pop)
      rd_ptr_d = rd_ptr_q + 1'b1;
    if (accept)
      wr_ptr_d = wr_ptr_q + 1'b1;
    if (accept && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !accept)
      count_d = count_q - 1'b1;
    if (push && !accept)
      ovf_d = 1'b1;
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Record storage; contents are only observed through count-gated outputs
  always_ff @(posedge Clk) begin
    if (accept) begin
      mem_bit_q[wr_ptr_q] <= push_bit;
      mem_len_q[wr_ptr_q] <= push_len;
    end
  end

  assign out_if.Out_valid = not_empty;
  assign out_if.Out_bit   = not_empty & mem_bit_q[rd_ptr_q];
  assign out_if.Out_len   = not_empty ? mem_len_q[rd_ptr_q] : '0;
  assign Overflow         = ovf_q;
  assign Fifo_count       = count_q;

endmodule

// File: tb/tb_run_length_encoder.sv
module tb_run_length_encoder;
  localparam int CNT_W = 8;
  localparam int DEPTH = 4;
  localparam int LMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic x_s = 1'b0;
  logic flush_s = 1'b0;
  logic prev_x;
  logic edge_s;
  logic ovf_o;
  logic [$clog2(DEPTH):0] cnt_o;

  run_length_encoder_if #(.CNT_W(CNT_W)) out_if ();

  run_length_encoder #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .Clk        (clk),
    .Clr        (clr),
    .X          (x_s),
    .Edge       (edge_s),
    .Flush      (flush_s),
    .out_if     (out_if.master),
    .Overflow   (ovf_o),
    .Fifo_count (cnt_o)
  );

  always #5 clk = ~clk;

  // Upstream bit-change detector
  always @(posedge clk or posedge clr)
    if (clr) prev_x <= 1'b0;
    else     prev_x <= x_s;
  assign edge_s = x_s ^ prev_x;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: records as {bit, len}
  logic [CNT_W:0] q[$];
  bit m_open;
  bit m_bit;
  int m_len;
  bit m_ovf;

  task automatic model_reset();
    q.delete();
    m_open = 0;
    m_bit  = 0;
    m_len  = 0;
    m_ovf  = 0;
  endtask

  task automatic check_outputs();
    logic [CNT_W:0] head;
    bit v;
    v = (q.size() != 0);
    head = v ? q[0] : '0;
    chk("valid", out_if.Out_valid, v);
    chk("bit", out_if.Out_bit, head[CNT_W]);
    chk("len", out_if.Out_len, head[CNT_W-1:0]);
    chk("count", cnt_o, q.size());
    chk("overflow", ovf_o, m_ovf);
  endtask

  // One cycle: check at negedge, drive inputs, advance model to next posedge
  task automatic step(input bit x, input bit fl, input bit rdy);
    bit push, pop;
    logic [CNT_W:0] rec;
    int sz;
    check_outputs();
    x_s = x;
    flush_s = fl;
    out_if.Out_ready = rdy;
    push = 0;
    rec = '0;
    if (!m_open) begin
      m_open = 1; m_bit = x; m_len = 1;
    end else if (fl) begin
      push = 1; rec = {m_bit, CNT_W'(m_len)}; m_open = 0;
    end else if (x != m_bit) begin
      push = 1; rec = {m_bit, CNT_W'(m_len)}; m_bit = x; m_len = 1;
    end else if (m_len == LMAX) begin
      push = 1; rec = {m_bit, CNT_W'(LMAX)}; m_len = 1;
    end else begin
      m_len++;
    end
    sz = q.size();
    pop = (sz != 0) && rdy;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) q.push_back(rec);
      else m_ovf = 1;
    end
    @(negedge clk);
  endtask

  // Asynchronous clear between clock edges
  task automatic do_clr();
    #2;
    clr = 1'b1;
    #1;
    chk("clr_valid", out_if.Out_valid, 1'b0);
    chk("clr_count", cnt_o, 0);
    chk("clr_len", out_if.Out_len, 0);
    chk("clr_bit", out_if.Out_bit, 1'b0);
    chk("clr_ovf", ovf_o, 1'b0);
    x_s = 1'b0;
    flush_s = 1'b0;
    model_reset();
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    bit xr;
    out_if.Out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", out_if.Out_valid, 1'b0);
    chk("rst_count", cnt_o, 0);
    chk("rst_len", out_if.Out_len, 0);
    chk("rst_ovf", ovf_o, 1'b0);
    @(negedge clk);
    clr = 1'b0;

    // Basic runs
    step(0,0,1); step(0,0,1); step(0,0,1); step(1,0,1);
    chk("basic_head_len", out_if.Out_len, 3);
    chk("basic_head_bit", out_if.Out_bit, 1'b0);
    step(1,0,1); step(0,0,1); step(0,1,1);
    for (int i = 0; i < 3; i++) step(0,0,1);

    // Saturation
    do_clr();
    for (int i = 0; i < 256; i++) step(1,0,1);
    chk("sat_len", out_if.Out_len, LMAX);
    step(1,0,1); step(0,0,1);
    chk("sat_tail_len", out_if.Out_len, 2);
    chk("sat_tail_bit", out_if.Out_bit, 1'b1);
    for (int i = 0; i < 3; i++) step(0,0,1);

    // Overflow and drain
    do_clr();
    for (int i = 0; i < 6; i++) step(i[0],0,0);
    chk("ovf_count", cnt_o, DEPTH);
    chk("ovf_flag", ovf_o, 1'b1);
    for (int i = 0; i < 6; i++) step(1,0,1);
    chk("ovf_sticky", ovf_o, 1'b1);
    chk("ovf_drained", cnt_o, 0);

    // Push and pop while full
    do_clr();
    step(0,0,0); step(1,0,0); step(0,0,0); step(1,0,0); step(0,0,0);
    chk("full_count", cnt_o, DEPTH);
    step(1,0,1);
    chk("pp_count", cnt_o, DEPTH);
    chk("pp_ovf", ovf_o, 1'b0);
    for (int i = 0; i < 6; i++) step(1,0,1);

    // Clear mid-operation
    do_clr();
    step(0,0,0); step(1,0,0); step(0,0,0);
    for (int i = 0; i < 4; i++) step(0,0,0);
    chk("mid_count", cnt_o, 2);
    do_clr();
    step(1,0,1); step(1,0,1); step(0,0,1);
    chk("postclr_len", out_if.Out_len, 2);
    chk("postclr_bit", out_if.Out_bit, 1'b1);
    step(0,0,1); step(0,0,1);

    // Flush together with Edge
    do_clr();
    for (int i = 0; i < 4; i++) step(0,0,1);
    step(1,1,1);
    chk("fe_len", out_if.Out_len, 4);
    chk("fe_count", cnt_o, 1);
    step(1,0,1); step(0,0,1);
    chk("fe_new_len", out_if.Out_len, 1);
    chk("fe_new_bit", out_if.Out_bit, 1'b1);
    step(0,0,1);

    // Randomized traffic
    do_clr();
    xr = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0,3) == 0) xr = ~xr;
      step(xr, ($urandom_range(0,19) == 0), ($urandom_range(0,1) == 1));
    end
    for (int i = 0; i < 8; i++) step(xr,0,1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
